// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_updown_counter
//  Brief    : Parametrised modulo up/down counter with prescaled enable,
//             clear/load, wrap or saturate mode, boundary pulse and sticky flag.
//  Revision : 1.0
// ============================================================================
module mod_updown_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     PRESCALE = 1,
    parameter int unsigned     SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             ovf
);

    localparam int unsigned      c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]  c_PRE_LAST = c_PW'(PRESCALE - 1);
    // One extra bit so MODULUS = 2**WIDTH is representable for the load compare.
    localparam logic [WIDTH:0]   c_MOD      = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_MAX      = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_cnt;
    logic [c_PW-1:0]  r_pre;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_term;
    logic             w_step;
    logic             w_at_bound;
    logic             w_over;
    logic [WIDTH-1:0] w_cnt_step;
    logic [WIDTH-1:0] w_load_cnt;
    logic [c_PW-1:0]  w_pre_next;

    assign w_term     = (r_pre == c_PRE_LAST);
    assign w_step     = en & w_term;
    assign w_at_bound = up ? (r_cnt == c_MAX) : (r_cnt == '0);
    assign w_over     = ({1'b0, load_val} >= c_MOD);
    assign w_load_cnt = w_over ? c_MAX : load_val;
    assign w_pre_next = w_term ? '0 : (r_pre + c_PW'(1));

    always_comb begin
        w_cnt_step = r_cnt;
        if (!w_at_bound) begin
            w_cnt_step = up ? (r_cnt + WIDTH'(1)) : (r_cnt - WIDTH'(1));
        end else if (SATURATE == 0) begin
            w_cnt_step = up ? '0 : c_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_pre  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_cnt  <= w_load_cnt;
            r_pre  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= r_ovf | w_over;
        end else begin
            r_wrap <= 1'b0;
            if (en) begin
                r_pre <= w_pre_next;
            end
            if (w_step) begin
                r_cnt <= w_cnt_step;
                // A boundary step flags in both wrap and saturate modes.
                if (w_at_bound) begin
                    r_wrap <= 1'b1;
                    r_ovf  <= 1'b1;
                end
            end
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_updown_counter
//  Brief    : Self-checking bench: three counter configurations, vector table
//             plus hand-written corner sequences, scoreboard queue.
//  Revision : 1.0
// ============================================================================
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] lv;

    logic [7:0] cnt_a;
    logic       wrap_a, ovf_a;
    logic [3:0] cnt_b;
    logic       wrap_b, ovf_b;
    logic [3:0] cnt_c;
    logic       wrap_c, ovf_c;

    int n_tests = 0;
    int n_fail  = 0;

    // A: full-range wrap counter, B: mod-10 prescaled by 3, C: mod-10 saturating
    mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .cnt(cnt_a), .wrap(wrap_a), .ovf(ovf_a));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[3:0]), .cnt(cnt_b), .wrap(wrap_b), .ovf(ovf_b));
    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[3:0]), .cnt(cnt_c), .wrap(wrap_c), .ovf(ovf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         dut;
        logic [7:0] cnt;
        logic       wrap;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       en;
        logic       up;
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       wrap;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    task automatic expect_v(input string nm, input int d, input logic [7:0] c,
                            input logic w, input logic o);
        exp_t e;
        e.name = nm;
        e.dut  = d;
        e.cnt  = c;
        e.wrap = w;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [7:0] ac;
        logic       aw, ao;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin ac = cnt_a;         aw = wrap_a; ao = ovf_a; end
                1:       begin ac = {4'b0, cnt_b}; aw = wrap_b; ao = ovf_b; end
                default: begin ac = {4'b0, cnt_c}; aw = wrap_c; ao = ovf_c; end
            endcase
            n_tests++;
            if (ac !== e.cnt || aw !== e.wrap || ao !== e.ovf) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d wrap=%b ovf=%b, want cnt=%0d wrap=%b ovf=%b",
                         e.name, ac, aw, ao, e.cnt, e.wrap, e.ovf);
            end
        end
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic drive(input logic e, input logic u, input logic c,
                         input logic l, input logic [7:0] v);
        en   = e;
        up   = u;
        clr  = c;
        load = l;
        lv   = v;
    endtask

    task automatic add(input logic e, input logic u, input logic c, input logic l,
                       input logic [7:0] v, input logic [7:0] xc, input logic xw,
                       input logic xo);
        vec_t t;
        t.en = e; t.up = u; t.clr = c; t.load = l; t.lv = v;
        t.cnt = xc; t.wrap = xw; t.ovf = xo;
        tbl.push_back(t);
    endtask

    initial begin
        // Vectors for B (MODULUS 10, PRESCALE 3); expected values after each edge.
        add(1,1,0,0,0,  0,0,0);   // pre 1
        add(1,1,0,0,0,  0,0,0);   // pre 2
        add(1,1,0,0,0,  1,0,0);   // step
        add(1,1,0,0,0,  1,0,0);   // pre 1
        for (int k = 0; k < 5; k++) add(0,k[0],0,0,0, 1,0,0);  // en low, up toggling
        add(1,1,0,0,0,  1,0,0);   // pre 2 (phase kept)
        add(1,1,0,0,0,  2,0,0);
        add(1,1,0,0,0,  2,0,0);
        add(1,1,0,0,0,  2,0,0);
        add(1,1,0,0,0,  3,0,0);
        add(1,1,0,0,0,  3,0,0);
        add(1,1,0,0,0,  3,0,0);   // pre 2
        add(1,1,0,1,8,  8,0,0);   // load on terminal cycle: step lost
        add(1,1,0,0,0,  8,0,0);
        add(1,1,0,0,0,  8,0,0);
        add(1,1,0,0,0,  9,0,0);
        add(1,1,0,0,0,  9,0,0);
        add(1,1,0,0,0,  9,0,0);
        add(1,1,0,0,0,  0,1,1);   // 9 -> 0 boundary
        add(1,1,0,0,0,  0,0,1);
        add(1,1,0,0,0,  0,0,1);   // pre 2
        add(1,1,1,1,5,  0,0,0);   // clr+load+en at terminal: clr wins
        add(1,1,0,0,0,  0,0,0);   // prescaler restarted
        add(1,1,0,0,0,  0,0,0);
        add(1,1,0,0,0,  1,0,0);
        add(0,1,0,1,12, 9,0,1);   // clamp
        add(0,1,1,0,0,  0,0,0);
        add(1,0,0,0,0,  0,0,0);
        add(1,0,0,0,0,  0,0,0);
        add(1,0,0,0,0,  9,1,1);   // down wrap 0 -> 9
        add(1,0,0,0,0,  9,0,1);

        drive(0,1,0,0,0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) expect_v("reset", d, 8'd0, 1'b0, 1'b0);
        check_now();
        @(negedge clk);
        #2 rst = 1'b1;

        // A: 260 steps through the full range.
        drive(1,1,0,0,0);
        for (int i = 1; i <= 260; i++) begin
            expect_v($sformatf("A run %0d", i), 0, 8'(i % 256), i == 256, i >= 256);
            tick_check();
        end

        drive(0,1,1,0,0);
        for (int d = 0; d < 3; d++) expect_v("clr all", d, 8'd0, 1'b0, 1'b0);
        tick_check();

        // B: full 0..9 cycle, one step every 3rd enabled cycle.
        drive(1,1,0,0,0);
        for (int k = 1; k <= 30; k++) begin
            expect_v($sformatf("B cycle %0d", k), 1, 8'((k / 3) % 10), k == 30, k == 30);
            tick_check();
        end
        drive(0,1,1,0,0);
        expect_v("B clr", 1, 8'd0, 1'b0, 1'b0);
        tick_check();

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].en, tbl[r].up, tbl[r].clr, tbl[r].load, tbl[r].lv);
            expect_v($sformatf("B vec %0d", r), 1, tbl[r].cnt, tbl[r].wrap, tbl[r].ovf);
            tick_check();
        end

        // C: saturating count-down from 7 then pinned at 0.
        drive(0,0,1,0,0);
        expect_v("C clr", 2, 8'd0, 1'b0, 1'b0);
        tick_check();
        drive(0,0,0,1,7);
        expect_v("C load 7", 2, 8'd7, 1'b0, 1'b0);
        tick_check();
        drive(1,0,0,0,0);
        for (int j = 1; j <= 12; j++) begin
            expect_v($sformatf("C down %0d", j), 2, (j <= 7) ? 8'(7 - j) : 8'd0,
                     j >= 8, j >= 8);
            tick_check();
        end
        drive(0,0,0,0,0);
        expect_v("C idle", 2, 8'd0, 1'b0, 1'b1);
        tick_check();
        drive(0,1,0,1,9);
        expect_v("C load 9", 2, 8'd9, 1'b0, 1'b1);
        tick_check();
        drive(1,1,0,0,0);
        expect_v("C sat top 1", 2, 8'd9, 1'b1, 1'b1);
        tick_check();
        expect_v("C sat top 2", 2, 8'd9, 1'b1, 1'b1);
        tick_check();

        // Asynchronous reset between edges while C holds 5.
        drive(0,1,0,1,5);
        expect_v("C load 5", 2, 8'd5, 1'b0, 1'b1);
        tick_check();
        drive(0,1,0,0,0);
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) expect_v("async rst", d, 8'd0, 1'b0, 1'b0);
        check_now();
        drive(1,1,0,0,0);
        expect_v("rst held", 2, 8'd0, 1'b0, 1'b0);
        tick_check();
        @(negedge clk);
        rst = 1'b1;
        expect_v("after rst", 2, 8'd1, 1'b0, 1'b0);
        expect_v("B after rst", 1, 8'd0, 1'b0, 1'b0);
        tick_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
